// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully-connected layer: LANES MACs per cycle over a latched feature vector,
// requantised, saturated, optional ReLU, streamed out on a valid/ready port.
module fc_layer_seq #(
  parameter int NEURONS  = 100,
  parameter int FEATURES = 128,
  parameter int DATA_W   = 8,
  parameter int LANES    = 4,
  parameter int ACC_W    = 24,
  parameter int SHIFT    = 7,
  parameter int RELU_EN  = 1,
  localparam int K  = FEATURES / LANES,
  localparam int AW = (NEURONS * K > 1) ? $clog2(NEURONS * K) : 1,
  localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [DATA_W*FEATURES-1:0]   feature,
  output logic                         busy,
  output logic                         w_rd_en,
  output logic [AW-1:0]                w_addr,
  input  logic [DATA_W*LANES-1:0]      w_data,
  output logic                         b_rd_en,
  output logic [NW-1:0]                b_addr,
  input  logic [DATA_W-1:0]            b_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [NW-1:0]                out_index,
  output logic                         done
);
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_RQ    = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic signed [ACC_W:0] SAT_MAX = $signed({{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] SAT_MIN = $signed({{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}});

  logic [2:0]                  state_r;
  logic [DATA_W*FEATURES-1:0]  feat_r;
  logic [NW-1:0]               neuron_r;
  logic [CW-1:0]               chunk_r;
  logic [CW-1:0]               pend_chunk_r;
  logic                        pend_r;
  logic                        b_pend_r;
  logic signed [ACC_W-1:0]     acc_r;
  logic signed [DATA_W-1:0]    bias_r;
  logic                        busy_r, w_rd_en_r, b_rd_en_r, out_valid_r, done_r;
  logic [AW-1:0]               w_addr_r;
  logic [NW-1:0]               b_addr_r, out_index_r;
  logic [DATA_W-1:0]           out_data_r;

  logic [DATA_W*LANES-1:0]     feat_chunk_s [K];
  logic [DATA_W*LANES-1:0]     feat_sel_s;
  logic signed [2*DATA_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]     mac_sum_s;
  logic signed [ACC_W-1:0]     shifted_s;
  logic signed [ACC_W:0]       biased_s;
  logic [DATA_W-1:0]           sat_s;
  logic [DATA_W-1:0]           rq_s;

  for (genvar c = 0; c < K; c++) begin : g_chunk
    assign feat_chunk_s[c] = feat_r[c*LANES*DATA_W +: LANES*DATA_W];
  end

  // Sum of lane products for the chunk whose weights are returning this cycle.
  always_comb begin
    feat_sel_s = feat_chunk_s[pend_chunk_r];
    prod_s     = '0;
    mac_sum_s  = '0;
    for (int l = 0; l < LANES; l++) begin
      prod_s    = $signed(feat_sel_s[l*DATA_W +: DATA_W]) * $signed(w_data[l*DATA_W +: DATA_W]);
      mac_sum_s = mac_sum_s + ACC_W'(prod_s);
    end
  end

  // Requantise: floor shift, bias add one bit wider, saturate, optional ReLU.
  always_comb begin
    shifted_s = acc_r >>> SHIFT;
    biased_s  = $signed({shifted_s[ACC_W-1], shifted_s}) +
                $signed({{(ACC_W+1-DATA_W){bias_r[DATA_W-1]}}, bias_r});
    if (biased_s > SAT_MAX) begin
      sat_s = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (biased_s < SAT_MIN) begin
      sat_s = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_s = biased_s[DATA_W-1:0];
    end
    if ((RELU_EN != 0) && sat_s[DATA_W-1]) begin
      rq_s = '0;
    end else begin
      rq_s = sat_s;
    end
  end

  // Sequencer: issues reads in MAC, accumulates one cycle behind, then requantises and hands off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      feat_r       <= '0;
      neuron_r     <= '0;
      chunk_r      <= '0;
      pend_chunk_r <= '0;
      pend_r       <= 1'b0;
      b_pend_r     <= 1'b0;
      acc_r        <= '0;
      bias_r       <= '0;
      busy_r       <= 1'b0;
      w_rd_en_r    <= 1'b0;
      w_addr_r     <= '0;
      b_rd_en_r    <= 1'b0;
      b_addr_r     <= '0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_index_r  <= '0;
      done_r       <= 1'b0;
    end else begin
      done_r       <= 1'b0;
      pend_r       <= w_rd_en_r;
      pend_chunk_r <= chunk_r;
      b_pend_r     <= b_rd_en_r;
      if (b_pend_r) begin
        bias_r <= b_data;
      end
      case (state_r)
        S_IDLE: begin
          if (start) begin
            feat_r    <= feature;
            neuron_r  <= '0;
            chunk_r   <= '0;
            acc_r     <= '0;
            busy_r    <= 1'b1;
            w_rd_en_r <= 1'b1;
            w_addr_r  <= '0;
            b_rd_en_r <= 1'b1;
            b_addr_r  <= '0;
            state_r   <= S_MAC;
          end
        end
        S_MAC: begin
          if (pend_r) begin
            acc_r <= acc_r + mac_sum_s;
          end
          b_rd_en_r <= 1'b0;
          if (chunk_r == CW'(K - 1)) begin
            w_rd_en_r <= 1'b0;
            state_r   <= S_DRAIN;
          end else begin
            chunk_r  <= chunk_r + CW'(1);
            w_addr_r <= w_addr_r + AW'(1);
          end
        end
        S_DRAIN: begin
          if (pend_r) begin
            acc_r <= acc_r + mac_sum_s;
          end
          state_r <= S_RQ;
        end
        S_RQ: begin
          out_data_r  <= rq_s;
          out_index_r <= neuron_r;
          out_valid_r <= 1'b1;
          state_r     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (neuron_r == NW'(NEURONS - 1)) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= S_IDLE;
            end else begin
              // w_addr already sits on the previous neuron's last word, so +1 starts the next row.
              neuron_r  <= neuron_r + NW'(1);
              chunk_r   <= '0;
              acc_r     <= '0;
              w_rd_en_r <= 1'b1;
              w_addr_r  <= w_addr_r + AW'(1);
              b_rd_en_r <= 1'b1;
              b_addr_r  <= neuron_r + NW'(1);
              state_r   <= S_MAC;
            end
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign w_rd_en   = w_rd_en_r;
  assign w_addr    = w_addr_r;
  assign b_rd_en   = b_rd_en_r;
  assign b_addr    = b_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_index = out_index_r;
  assign done      = done_r;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq: three instances (SHIFT/RELU variants) share stimulus and memory contents.
module tb_fc_layer_seq;
  localparam int N  = 3;
  localparam int F  = 8;
  localparam int L  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, start, out_ready;
  logic [DW*F-1:0] feature;

  logic        busy [3];
  logic        w_rd_en [3];
  logic [2:0]  w_addr [3];
  logic [31:0] w_data [3];
  logic        b_rd_en [3];
  logic [1:0]  b_addr [3];
  logic [7:0]  b_data [3];
  logic        out_valid [3];
  logic [7:0]  out_data [3];
  logic [1:0]  out_index [3];
  logic        done [3];

  logic [31:0] wmem [8];
  logic [7:0]  bmem [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut 0: SHIFT 0, ReLU on; dut 1: SHIFT 0, ReLU off; dut 2: SHIFT 7, ReLU off
  fc_layer_seq #(.NEURONS(N), .FEATURES(F), .DATA_W(DW), .LANES(L), .ACC_W(24), .SHIFT(0), .RELU_EN(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .feature(feature), .busy(busy[0]),
    .w_rd_en(w_rd_en[0]), .w_addr(w_addr[0]), .w_data(w_data[0]),
    .b_rd_en(b_rd_en[0]), .b_addr(b_addr[0]), .b_data(b_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
    .out_index(out_index[0]), .done(done[0]));
  fc_layer_seq #(.NEURONS(N), .FEATURES(F), .DATA_W(DW), .LANES(L), .ACC_W(24), .SHIFT(0), .RELU_EN(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .feature(feature), .busy(busy[1]),
    .w_rd_en(w_rd_en[1]), .w_addr(w_addr[1]), .w_data(w_data[1]),
    .b_rd_en(b_rd_en[1]), .b_addr(b_addr[1]), .b_data(b_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
    .out_index(out_index[1]), .done(done[1]));
  fc_layer_seq #(.NEURONS(N), .FEATURES(F), .DATA_W(DW), .LANES(L), .ACC_W(24), .SHIFT(7), .RELU_EN(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .feature(feature), .busy(busy[2]),
    .w_rd_en(w_rd_en[2]), .w_addr(w_addr[2]), .w_data(w_data[2]),
    .b_rd_en(b_rd_en[2]), .b_addr(b_addr[2]), .b_data(b_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]),
    .out_index(out_index[2]), .done(done[2]));

  for (genvar g = 0; g < 3; g++) begin : g_mem
    always @(posedge clk) begin
      if (w_rd_en[g]) w_data[g] <= wmem[w_addr[g]];
      if (b_rd_en[g]) b_data[g] <= bmem[b_addr[g]];
    end
  end

  // results of the most recent run_layer, times relative to the start-accept edge
  int         n_res, acc_cyc, done_cyc, done_cnt;
  int         r_first [8];
  int         r_hs [8];
  logic [7:0] r_d [3][8];
  logic [1:0] r_idx [8];
  bit         timed_out, unstable, rd_in_out;

  task automatic fill(input logic [7:0] f, input logic [7:0] w, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [7:0] b2);
    feature = {F{f}};
    for (int i = 0; i < 8; i++) wmem[i] = {L{w}};
    bmem[0] = b0; bmem[1] = b1; bmem[2] = b2; bmem[3] = 8'h00;
  endtask

  task automatic run_layer(input int stall_n, input int stall_cyc, input bit poke);
    int   stall_left, after;
    bit   was_valid;
    logic [7:0] hold_d;
    logic [1:0] hold_i;
    n_res = 0; done_cnt = 0; done_cyc = -1; timed_out = 1'b1; unstable = 1'b0; rd_in_out = 1'b0;
    stall_left = stall_cyc; was_valid = 1'b0; after = 0; hold_d = 8'h00; hold_i = 2'd0;
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; acc_cyc = cyc;
    for (int it = 0; it < 200; it++) begin
      if (poke && (it == 2 || it == 11)) begin start = 1'b1; feature = ~feature; end
      if (poke && (it == 3 || it == 12)) start = 1'b0;
      if (out_valid[0]) begin
        if (!was_valid) begin
          if (n_res < 8) begin
            r_first[n_res] = cyc - acc_cyc;
            for (int g = 0; g < 3; g++) r_d[g][n_res] = out_data[g];
            r_idx[n_res] = out_index[0];
          end
          hold_d = out_data[0]; hold_i = out_index[0];
        end else if (out_data[0] !== hold_d || out_index[0] !== hold_i) begin
          unstable = 1'b1;
        end
        if (w_rd_en[0] || b_rd_en[0]) rd_in_out = 1'b1;
        if (int'(out_index[0]) == stall_n && stall_left > 0) begin
          out_ready = 1'b0; stall_left--;
        end else begin
          out_ready = 1'b1;
        end
        if (out_ready) begin
          if (n_res < 8) r_hs[n_res] = cyc + 1 - acc_cyc;
          n_res++; was_valid = 1'b0;
        end else begin
          was_valid = 1'b1;
        end
      end else begin
        out_ready = 1'b1; was_valid = 1'b0;
      end
      if (done[0]) begin
        if (done_cnt == 0) done_cyc = cyc - acc_cyc;
        done_cnt++;
      end
      if (done_cnt > 0) begin
        after++;
        if (after > 2) begin timed_out = 1'b0; break; end
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; feature = '0;
    fill(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    checks++;
    if ({busy[0], w_rd_en[0], b_rd_en[0], out_valid[0], done[0]} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {busy[0], w_rd_en[0], b_rd_en[0], out_valid[0], done[0]});
    end
    checks++;
    if ({w_addr[0], b_addr[0], out_data[0], out_index[0]} !== 15'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {w_addr[0], b_addr[0], out_data[0], out_index[0]});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] e0 [3] = '{8'd16, 8'd17, 8'd13};
    logic [7:0] e2 [3] = '{8'h00, 8'h01, 8'hFD};
    fill(8'd1, 8'd2, 8'd0, 8'd1, 8'hFD);
    run_layer(-1, 0, 1'b0);
    checks++;
    if (timed_out || n_res != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3 timeout=%0d", n_res, timed_out); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (r_idx[k] !== 2'(k)) begin failures++; $display("FAIL basic_index%0d got=%0d exp=%0d", k, r_idx[k], k); end
      checks++;
      if (r_d[0][k] !== e0[k]) begin failures++; $display("FAIL basic_data%0d got=%0d exp=%0d", k, r_d[0][k], e0[k]); end
      checks++;
      if (r_d[2][k] !== e2[k]) begin failures++; $display("FAIL basic_shift7_%0d got=%h exp=%h", k, r_d[2][k], e2[k]); end
    end
    checks++;
    if (r_first[0] != 4) begin failures++; $display("FAIL first_latency got=%0d exp=4", r_first[0]); end
    checks++;
    if (r_first[1] - r_first[0] != 5 || r_first[2] - r_first[1] != 5) begin
      failures++; $display("FAIL spacing got=%0d,%0d exp=5,5", r_first[1] - r_first[0], r_first[2] - r_first[1]);
    end
    checks++;
    if (done_cyc != r_hs[2] || done_cnt != 1) begin
      failures++; $display("FAIL done_pulse got=at%0d x%0d exp=at%0d x1", done_cyc, done_cnt, r_hs[2]);
    end
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL busy_after got=%b exp=0", busy[0]); end
  endtask

  task automatic test_mapping;
    logic [7:0] e0 [3] = '{8'h00, 8'd35, 8'd103};
    logic [7:0] e1 [3] = '{8'hDA, 8'd35, 8'd103};
    logic [7:0] e2 [3] = '{8'hFF, 8'h01, 8'hFD};
    logic [7:0] v;
    fill(8'd0, 8'd0, 8'd0, 8'd1, 8'hFD);
    for (int j = 0; j < F; j++) begin v = 8'(j + 1); feature[j*8 +: 8] = v; end
    for (int i = 0; i < 8; i++)
      for (int l = 0; l < L; l++) begin v = 8'(i - l); wmem[i][l*8 +: 8] = v; end
    run_layer(-1, 0, 1'b0);
    checks++;
    if (timed_out || n_res != 3) begin failures++; $display("FAIL map_count got=%0d exp=3", n_res); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({r_d[0][k], r_d[1][k], r_d[2][k]} !== {e0[k], e1[k], e2[k]}) begin
        failures++; $display("FAIL map_data%0d got=%h/%h/%h exp=%h/%h/%h", k, r_d[0][k], r_d[1][k], r_d[2][k], e0[k], e1[k], e2[k]);
      end
    end
  endtask

  task automatic test_saturation;
    fill(8'd127, 8'd127, 8'd0, 8'd0, 8'd0);
    run_layer(-1, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (r_d[2][k] !== 8'h7F || r_d[0][k] !== 8'h7F) begin
        failures++; $display("FAIL sat_pos%0d got=%h/%h exp=7f/7f", k, r_d[2][k], r_d[0][k]);
      end
    end
    fill(8'd127, 8'h80, 8'd0, 8'd0, 8'd0);
    run_layer(-1, 0, 1'b0);
    checks++;
    if (timed_out || n_res != 3) begin failures++; $display("FAIL sat_count got=%0d exp=3", n_res); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({r_d[2][k], r_d[1][k], r_d[0][k]} !== {8'h80, 8'h80, 8'h00}) begin
        failures++; $display("FAIL sat_neg%0d got=%h/%h/%h exp=80/80/00", k, r_d[2][k], r_d[1][k], r_d[0][k]);
      end
    end
  endtask

  task automatic test_relu;
    fill(8'd10, 8'hFF, 8'd0, 8'd0, 8'd0);
    run_layer(-1, 0, 1'b0);
    checks++;
    if (timed_out || n_res != 3) begin failures++; $display("FAIL relu_count got=%0d exp=3", n_res); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({r_d[0][k], r_d[1][k], r_d[2][k]} !== {8'h00, 8'hB0, 8'hFF}) begin
        failures++; $display("FAIL relu%0d got=%h/%h/%h exp=00/b0/ff", k, r_d[0][k], r_d[1][k], r_d[2][k]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] e0 [3] = '{8'd16, 8'd17, 8'd13};
    fill(8'd1, 8'd2, 8'd0, 8'd1, 8'hFD);
    run_layer(1, 6, 1'b0);
    checks++;
    if (timed_out || n_res != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", n_res); end
    checks++;
    if (unstable) begin failures++; $display("FAIL bp_stable got=changed exp=held"); end
    checks++;
    if (rd_in_out) begin failures++; $display("FAIL bp_reads got=read_in_OUT exp=none"); end
    checks++;
    if (r_first[2] - r_first[1] != 11) begin failures++; $display("FAIL bp_spacing got=%0d exp=11", r_first[2] - r_first[1]); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (r_d[0][k] !== e0[k] || r_idx[k] !== 2'(k)) begin
        failures++; $display("FAIL bp_data%0d got=%0d@%0d exp=%0d@%0d", k, r_d[0][k], r_idx[k], e0[k], k);
      end
    end
  endtask

  task automatic test_start_rules;
    logic [7:0] e0 [3] = '{8'd16, 8'd17, 8'd13};
    fill(8'd1, 8'd2, 8'd0, 8'd1, 8'hFD);
    run_layer(-1, 0, 1'b1);
    checks++;
    if (timed_out || n_res != 3 || r_first[2] != 14) begin
      failures++; $display("FAIL start_timing got=n%0d t%0d exp=n3 t14", n_res, r_first[2]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (r_d[0][k] !== e0[k]) begin failures++; $display("FAIL start_data%0d got=%0d exp=%0d", k, r_d[0][k], e0[k]); end
    end
  endtask

  task automatic test_reset_mid;
    fill(8'd1, 8'd2, 8'd0, 8'd1, 8'hFD);
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1 || w_rd_en[0] !== 1'b1 || w_addr[0] !== 3'd3) begin
      failures++; $display("FAIL mid_mac got=busy%b rd%b addr%0d exp=busy1 rd1 addr3", busy[0], w_rd_en[0], w_addr[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy[0], w_rd_en[0], b_rd_en[0], out_valid[0], done[0], w_addr[0], b_addr[0], out_data[0], out_index[0]} !== 20'h0) begin
      failures++; $display("FAIL mid_reset got=%h exp=0",
        {busy[0], w_rd_en[0], b_rd_en[0], out_valid[0], done[0], w_addr[0], b_addr[0], out_data[0], out_index[0]});
    end
    @(negedge clk); rst_n = 1'b1;
    run_layer(-1, 0, 1'b0);
    checks++;
    if (timed_out || n_res != 3 || r_d[0][0] !== 8'd16 || r_idx[0] !== 2'd0) begin
      failures++; $display("FAIL restart got=%0d@%0d n%0d exp=16@0 n3", r_d[0][0], r_idx[0], n_res);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mapping();
    test_saturation();
    test_relu();
    test_backpressure();
    test_start_rules();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
